// File: rtl/dcache_2way.sv
// Two-way set-associative, write-through, no-write-allocate data cache with burst line refill.
// Defining DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module dcache_2way #(
  parameter int ADDR_WIDTH      = 32,
  parameter int SET_BITS        = 4,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  output logic [3:0]            mem_req_be,
  input  logic                  mem_resp_valid,
`ifdef DCACHE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  input  logic [31:0]           mem_resp_rdata
);
  localparam int SETS       = 1 << SET_BITS;
  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;
  localparam int OFF_W      = LINE_WORDS_LOG2 + 2;
  localparam int TAG_W      = ADDR_WIDTH - SET_BITS - OFF_W;
  localparam int CNT_W      = LINE_WORDS_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP, S_WRITE} state_e;
  typedef logic [TAG_W-1:0]           tag_t;
  typedef logic [SET_BITS-1:0]        set_t;
  typedef logic [LINE_WORDS_LOG2-1:0] word_t;

  state_e state_q, state_d;

  logic [1:0]      valid_q [SETS];
  tag_t            tag_q   [SETS][2];
  logic [SETS-1:0] lru_q;
  logic [31:0]     data_q  [2][SETS][LINE_WORDS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  way_q;
  logic [CNT_W-1:0]      issue_q;
  word_t                 rcv_q;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size);
    case (size)
      2'b01:   extract = {24'h0, w[8*off +: 8]};
      2'b10:   extract = {16'h0, off[1] ? w[31:16] : w[15:0]};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'b01:   lane_be = 4'b0001 << off;
      2'b10:   lane_be = off[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] size);
    case (size)
      2'b01:   lane_data = {4{d[7:0]}};
      2'b10:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  tag_t        req_tag, fill_tag;
  set_t        req_set, fill_set;
  word_t       req_word, fill_word;
  logic        hit0, hit1, hit, hit_way, victim, accept, fill_rsp, fill_last;
  logic [31:0] hit_word, fill_sel, req_wrep;
  logic [3:0]  req_be;

  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_set   = req_addr[OFF_W +: SET_BITS];
  assign req_word  = req_addr[2 +: LINE_WORDS_LOG2];
  assign fill_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign fill_set  = addr_q[OFF_W +: SET_BITS];
  assign fill_word = addr_q[2 +: LINE_WORDS_LOG2];

  assign hit0    = valid_q[req_set][0] && (tag_q[req_set][0] == req_tag);
  assign hit1    = valid_q[req_set][1] && (tag_q[req_set][1] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  // Empty ways are filled before anything valid is evicted.
  assign victim  = !valid_q[req_set][0] ? 1'b0 :
                   !valid_q[req_set][1] ? 1'b1 : lru_q[req_set];

  assign accept    = req_valid && (state_q == S_IDLE);
  assign fill_rsp  = (state_q == S_FILL) && mem_resp_valid;
  assign fill_last = fill_rsp && (rcv_q == word_t'(LINE_WORDS - 1));
  assign hit_word  = data_q[hit_way][req_set][req_word];
  // The requested word may be the one arriving on the closing response.
  assign fill_sel  = (rcv_q == fill_word) ? mem_resp_rdata : data_q[way_q][fill_set][fill_word];
  assign req_be    = lane_be(req_addr[1:0], req_size);
  assign req_wrep  = lane_data(req_wdata, req_size);

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = ((state_q == S_FILL) && !issue_q[CNT_W-1]) || (state_q == S_WRITE);
  assign mem_req_we    = (state_q == S_WRITE);
  assign mem_req_addr  = (state_q == S_WRITE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00}
                       : {addr_q[ADDR_WIDTH-1:OFF_W], issue_q[LINE_WORDS_LOG2-1:0], 2'b00};
  assign mem_req_wdata = (state_q == S_WRITE) ? wdata_q : 32'h0;
  assign mem_req_be    = (state_q == S_WRITE) ? be_q : 4'h0;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) begin
                 if (req_we)    state_d = S_WRITE;
                 else if (!hit) state_d = S_FILL;
               end
      S_FILL:  if (fill_last) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_WRITE: if (mem_req_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic        arr_we, arr_way;
  set_t        arr_set;
  word_t       arr_word;
  logic [31:0] arr_wdata;

  always_comb begin
    arr_we    = 1'b0;
    arr_way   = way_q;
    arr_set   = fill_set;
    arr_word  = rcv_q;
    arr_wdata = mem_resp_rdata;
    if (fill_rsp) begin
      arr_we = 1'b1;
    end else if (accept && req_we && hit) begin
      arr_we    = 1'b1;
      arr_way   = hit_way;
      arr_set   = req_set;
      arr_word  = req_word;
      arr_wdata = merge(hit_word, req_be, req_wrep);
    end
  end

  // NOTE: the line store has no reset; the valid bits alone decide whether its contents count.
  always_ff @(posedge clk) begin
    if (arr_we) data_q[arr_way][arr_set][arr_word] <= arr_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lru_q      <= '0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      way_q      <= 1'b0;
      issue_q    <= '0;
      rcv_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= 2'b00;
        tag_q[s][0] <= '0;
        tag_q[s][1] <= '0;
      end
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          wdata_q <= req_wrep;
          be_q    <= req_be;
          issue_q <= '0;
          rcv_q   <= '0;
          if (hit) begin
            lru_q[req_set] <= ~hit_way;
            if (!req_we) begin
              resp_valid <= 1'b1;
              resp_rdata <= extract(hit_word, req_addr[1:0], req_size);
            end
          end else if (!req_we) begin
            way_q                   <= victim;
            valid_q[req_set][victim] <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_req_valid && mem_req_ready) issue_q <= issue_q + CNT_W'(1);
          if (mem_resp_valid) rcv_q <= rcv_q + word_t'(1);
          if (fill_last) begin
            valid_q[fill_set][way_q] <= 1'b1;
            tag_q[fill_set][way_q]   <= fill_tag;
            lru_q[fill_set]          <= ~way_q;
            resp_valid               <= 1'b1;
            resp_rdata               <= extract(fill_sel, addr_q[1:0], size_q);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else if (accept) begin
      if (hit && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 32'h1;
      if (!hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'h1;
    end
  end
`endif

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Parametrised two-way set-associative, write-through, no-write-allocate data cache with multi-word lines and LRU replacement. It sits between the core's load/store unit and the backing data memory. Hits are served from the line store with one-cycle latency. Read misses run a burst refill over a valid/ready memory port. Load sign/zero extension is done downstream; this block returns zero-extended bytes and halves.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `SET_BITS`, 4: log2 of sets per way (default 16 sets).
- `LINE_WORDS_LOG2`, 2: log2 of 32-bit words per line (default 4 words, 16 B).
- Derived: `TAG_W = ADDR_WIDTH - SET_BITS - LINE_WORDS_LOG2 - 2`. Data width is fixed at 32.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: request accepted this cycle when `req_valid && req_ready`.
- `req_we` in 1: 1 write, 0 read.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: write data, LSB-aligned.
- `req_size` in 2: 00 word, 01 byte, 10 halfword, 11 treated as word.
- `resp_valid` out 1: read data valid, one-cycle pulse.
- `resp_rdata` out 32: read data, zero-extended for byte/half.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_req_we` out 1: memory write.
- `mem_req_addr` out ADDR_WIDTH: word-aligned byte address (bits [1:0] = 0).
- `mem_req_wdata` out 32, `mem_req_be` out 4: write data and byte enables.
- `mem_resp_valid` in 1, `mem_resp_rdata` in 32: read response, in request order, any latency ≥1.
- `hit_count`, `miss_count` out 32: present only with `DCACHE_STATS_EN`.

## Operation
- Address split, MSB to LSB: tag, set index (`SET_BITS`), word offset (`LINE_WORDS_LOG2`), byte offset (2). Misaligned half/word accesses are aligned down.
- Per set: valid and tag per way, plus one LRU bit naming the way to evict next. LRU points at the way not touched by the latest read hit, write hit or fill.
- FSM states: IDLE, FILL, RESP, WRITE.
- IDLE:
  - `req_ready` = 1.
  - Read hit: register the selected word/byte/half to `resp_rdata`, pulse `resp_valid`, stay in IDLE.
  - Read miss: choose the victim way. Invalid way 0 wins, then invalid way 1, otherwise the LRU way. Clear the victim's valid bit, go to FILL.
  - Write: on a hit, merge bytes into the hit way and update LRU. On a miss, leave the cache unchanged. Either way, go to WRITE.
- FILL:
  - Issue `LINE_WORDS` reads to line base + 4·i, i ascending; the issue counter advances on each accepted `mem_req`.
  - A separate receive counter writes each `mem_resp_rdata` into word i of the victim.
  - Issue and receive overlap.
  - After the last response: set valid, write tag, update LRU, go to RESP.
- RESP: `resp_valid` = 1 with the requested word/byte/half from the filled line, then go to IDLE.
- WRITE:
  - Hold `mem_req_valid`=1, `mem_req_we`=1 until `mem_req_ready`, then go to IDLE. Writes produce no `resp_valid`.
  - Byte enables: byte → `1<<addr[1:0]`; half → 0011 or 1100 by `addr[1]`; word → 1111.
  - Write data is lane-replicated: byte ×4, half ×2.
- `mem_resp_valid` outside FILL is ignored.

## Timing
- Reset values: state IDLE, all valid and LRU bits 0, `resp_valid` 0, `resp_rdata` 0, `mem_req_valid` 0, counters 0. `req_ready` = 1 during and after reset.
- Reset mid-FILL or mid-WRITE aborts immediately and leaves no partial line valid. The backing memory shares `rst_n`, so no stale responses survive.
- Read hit: `resp_valid` the cycle after acceptance. Back-to-back hits sustain one per cycle.
- Read miss, with `mem_req_ready`=1 and 1-cycle memory latency:
  - FILL requests in cycles 1..4 after acceptance.
  - Responses in cycles 2..5.
  - `resp_valid` in cycle 6.
  - `req_ready` is 0 for cycles 1..6.
- Write: `req_ready` is 0 from the cycle after acceptance until the cycle after the `mem_req` handshake.
- `mem_req_valid`, `mem_req_addr` and `mem_req_wdata` are stable while `mem_req_ready` = 0.
- Tag/valid/LRU lookup is combinational on `req_addr` in IDLE. Line-store writes land at the accepting edge.

## Configuration
- `DCACHE_STATS_EN` defined: add `hit_count` and `miss_count`.
  - `hit_count` increments on each accepted read or write hit.
  - `miss_count` increments on each accepted read or write miss.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold read of word 0x0000_0104; memory holds 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x100..0x10C → four reads at 0x100, 0x104, 0x108, 0x10C in order, `resp_rdata`=0x22222222. A following read of 0x108 → `resp_valid` next cycle with 0x33333333 and no `mem_req_valid`.
- Conflict on set 0:
  - Fill 0x104 and then 0x1104.
  - Read 0x104 again; this hit makes way 1 the LRU way.
  - Read 0x2104 → refill replaces the 0x1104 line.
  - A subsequent read of 0x104 hits; a read of 0x1104 misses.
- After filling line 0x100, byte write 0xAB to 0x105 → `mem_req_be`=0010, `mem_req_wdata`=0xABABABAB. A following word read of 0x104 hits with 0x2222AB22.
- Half write 0xBEEF to 0x3002 (line not cached) → be=1100, wdata=0xBEEFBEEF, cache unchanged. A following read of 0x3000 misses and refills.
- Assert `rst_n`=0 after the second refill response of a miss → `mem_req_valid` drops at once. After release, a read of the same address misses and refills all four words.
- With `DCACHE_STATS_EN`: sequence miss, hit, hit, write-miss → `hit_count`=2, `miss_count`=2.
